autoconfig_master: RTL and testbench
====================================

AUTOCONFIG_MASTER -- requirements
Module: autoconfig_master

Interface
REQ-001 Parameter TIMEOUT, default 64: clocks allowed between bus_req assertion and bus_ack before the cycle is treated as unanswered.
REQ-002 Parameter MAX_BOARDS, default 8: maximum boards configured per run.
REQ-003 CLK  in  1  system clock; all state changes on rising edge.
REQ-004 _RST  in  1  reset _RST, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse that begins a configuration run; ignored while busy=1.
REQ-006 bus_req  out  1  Zorro II bus cycle request to the bus engine.
REQ-007 bus_rw  out  1  1=read, 0=write.
REQ-008 bus_addr  out  24  byte address of the cycle.
REQ-009 bus_wdata  out  4  nibble driven on D15:12 for writes.
REQ-010 bus_ack  in  1  one-cycle pulse: cycle completed (DTACK seen).
REQ-011 bus_rdata  in  4  D15:12 read data, valid in the bus_ack cycle.
REQ-012 _cfgout  out  1  drives _CONFIGIN of the first slot; 0 while busy or done, 1 in reset/idle.
REQ-013 busy / done  out  1 each  run in progress / run finished (sticky until next start).
REQ-014 cfg_we  out  1  one-cycle pulse per board assigned; cfg_base 8 (A23:16), cfg_size 8 (64K units), cfg_idx 3 valid with it.
REQ-015 n_boards, n_shut  out  4 each  boards configured / boards shut up this run.
REQ-016 mem_top  out  8  allocation pointer (A23:16) after the last assignment.

Function
REQ-017 FSM states: IDLE, RD_TYPE, RD_SIZE, ALLOC, WR_LO, WR_HI, WR_SHUT, NEXT, DONE.
REQ-018 IDLE->RD_TYPE on start; counters cleared, pointer set to $20 ($200000).
REQ-019 Each bus state: raise bus_req with addr/rw/wdata stable until bus_ack or timeout; bus_req drops the cycle after ack; a new cycle never starts in the same cycle.
REQ-020 RD_TYPE reads $E80000; no ack within TIMEOUT clocks -> DONE (empty chain end); nibble[3:2]!=2'b11 -> WR_SHUT.
REQ-021 RD_SIZE reads $E80002 (not inverted); size code = nibble[2:0]: 000=8MB(128 units), 001..111=64K<<(code-1); timeout here -> DONE.
REQ-022 ALLOC, one cycle: base = pointer rounded up to size multiple; fits if base+size <= $A0; code 000 fits only when pointer=$20 (base $20); no fit -> WR_SHUT.
REQ-023 Arithmetic in 9 bits to avoid wrap; base and pointer are 8 bits.
REQ-024 Fit: WR_LO writes base[3:0] to $E8004A, then WR_HI writes base[7:4] to $E80048; cfg_we pulses on WR_HI ack; pointer=base+size; n_boards+1.
REQ-025 WR_SHUT writes $0 to $E8004C; n_shut+1; write timeout -> DONE.
REQ-026 NEXT: n_boards+n_shut = MAX_BOARDS -> DONE else RD_TYPE (next board's _CONFIGIN now low).
REQ-027 Write timeout in WR_LO/WR_HI -> DONE with no cfg_we.
REQ-028 DONE: done=1, busy=0, bus_req=0; start -> new run from $20.

Reset
REQ-029 _RST low asynchronously forces IDLE, bus_req=0, cfg_we=0, busy=0, done=0, _cfgout=1, counters 0, mem_top=$20, timeout counter 0.
REQ-030 Reset mid-cycle abandons the cycle; no partial write is retried after release.

Structure
REQ-031 Shared package holds state enum, autoconfig register offsets ($00,$02,$48,$4A,$4C), base $E80000, space limits $20/$A0, size-code table.
REQ-032 One sub-module autoconfig_alloc: combinational size decode, alignment, fit check.

Verification
REQ-033 One board $00=E,$02=6 -> writes $4A=0,$48=2; cfg_base=$20, cfg_size=32; mem_top=$40; n_boards=1; then timeout -> done.
REQ-034 No responder -> 64 clocks without ack -> done=1, n_boards=0, no write cycles.
REQ-035 512K (code 4) then 2MB -> first $48=2,$4A=0, base $20, pointer $28; second base $40, $48=4; mem_top=$60.
REQ-036 Three 4MB boards -> first base $40; second, third shut up via $4C; n_boards=1, n_shut=2, mem_top=$80.
REQ-037 $00 reads $5 -> $4C write, n_shut=1, next board probed.
REQ-038 _RST low during WR_HI before ack -> bus_req=0 same instant, no cfg_we; new start configures from $20.

Source files
------------

// File: rtl/autoconfig_master_pkg.sv
// Shared AutoConfig definitions: master FSM states, Zorro II AutoConfig register map,
// address-space limits and the board size-code table.
package autoconfig_master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_TYPE,
        ST_RD_SIZE,
        ST_ALLOC,
        ST_WR_LO,
        ST_WR_HI,
        ST_WR_SHUT,
        ST_NEXT,
        ST_DONE
    } ac_state_t;

    localparam logic [23:0] AC_BASE         = 24'hE8_0000;
    localparam logic [7:0]  AC_REG_TYPE     = 8'h00;
    localparam logic [7:0]  AC_REG_SIZE     = 8'h02;
    localparam logic [7:0]  AC_REG_BASE_HI  = 8'h48;
    localparam logic [7:0]  AC_REG_BASE_LO  = 8'h4A;
    localparam logic [7:0]  AC_REG_SHUT     = 8'h4C;

    // Zorro II expansion space in 64K units: $200000 up to (not including) $A00000.
    localparam logic [7:0]  SPACE_LO        = 8'h20;
    localparam logic [8:0]  SPACE_HI        = 9'h0A0;

    localparam logic [7:0]  SIZE_UNITS [8] = '{8'd128, 8'd1, 8'd2, 8'd4,
                                               8'd8,   8'd16, 8'd32, 8'd64};

    function automatic logic [7:0] size_units(input logic [2:0] code);
        return SIZE_UNITS[code];
    endfunction

    function automatic logic [23:0] ac_addr(input logic [7:0] off);
        return AC_BASE | {16'h0000, off};
    endfunction

endpackage

// File: rtl/autoconfig_master_if.sv
// Bus-engine handshake between the AutoConfig master and the Zorro II cycle generator.
interface autoconfig_master_if;

    logic        bus_req;
    logic        bus_rw;
    logic [23:0] bus_addr;
    logic [3:0]  bus_wdata;
    logic        bus_ack;
    logic [3:0]  bus_rdata;

    modport master (
        output bus_req,
        output bus_rw,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_rw,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/autoconfig_alloc.sv
// Combinational allocator: decodes the size code, aligns the pointer to the board size
// and checks the result still fits below the top of expansion space.
module autoconfig_alloc
    import autoconfig_master_pkg::*;
(
    input  logic [7:0] ptr,
    input  logic [2:0] size_code,
    output logic [7:0] base,
    output logic [7:0] size,
    output logic       fit
);

    logic [8:0] size9;
    logic [8:0] mask9;
    logic [8:0] base9;
    logic [8:0] end9;

    always_comb begin
        size9 = {1'b0, size_units(size_code)};
        mask9 = size9 - 9'd1;
        base9 = ({1'b0, ptr} + mask9) & ~mask9;
        end9  = base9 + size9;
        base  = base9[7:0];
        size  = size9[7:0];
        fit   = (end9 <= SPACE_HI);
        // An 8MB board only fits as the very first allocation, at the bottom of the space.
        if (size_code == 3'd0) begin
            base = SPACE_LO;
            fit  = (ptr == SPACE_LO);
        end
    end

endmodule

// File: rtl/autoconfig_master.sv
// Zorro II AutoConfig master: walks the _CONFIGIN chain, reads each board's type/size,
// assigns a base address or shuts the board up, and reports the resulting map.
//
// state      | meaning
// IDLE       | waiting for start, _cfgout high
// RD_TYPE    | read er_Type nibble at $E80000
// RD_SIZE    | read size nibble at $E80002
// ALLOC      | one-cycle alignment and fit check
// WR_LO      | write base[3:0] to $E8004A
// WR_HI      | write base[7:4] to $E80048, board assigned
// WR_SHUT    | write $0 to $E8004C, board shut up
// NEXT       | decide whether to probe another board
// DONE       | run finished, results held until next start
module autoconfig_master
    import autoconfig_master_pkg::*;
#(
    parameter int TIMEOUT    = 64,
    parameter int MAX_BOARDS = 8
) (
    input  logic                CLK,
    input  logic                _RST,
    input  logic                start,
    autoconfig_master_if.master bus,
    output logic                _cfgout,
    output logic                busy,
    output logic                done,
    output logic                cfg_we,
    output logic [7:0]          cfg_base,
    output logic [7:0]          cfg_size,
    output logic [2:0]          cfg_idx,
    output logic [3:0]          n_boards,
    output logic [3:0]          n_shut,
    output logic [7:0]          mem_top
);

    localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT - 1);
    localparam logic [4:0]     MAX_CNT  = 5'(MAX_BOARDS);

    ac_state_t     state_q, state_nxt;
    logic          req_q, req_nxt;
    logic [TW-1:0] tmr_q, tmr_nxt;
    logic [7:0]    ptr_q, ptr_nxt;
    logic [3:0]    nb_q, nb_nxt;
    logic [3:0]    ns_q, ns_nxt;
    logic [2:0]    code_q, code_nxt;
    logic [7:0]    base_q, base_nxt;
    logic [7:0]    size_q, size_nxt;
    logic          cfg_we_q, cfg_we_nxt;
    logic [7:0]    cfg_base_q, cfg_base_nxt;
    logic [7:0]    cfg_size_q, cfg_size_nxt;
    logic [2:0]    cfg_idx_q, cfg_idx_nxt;

    logic          bus_state;
    logic          ack_hit;
    logic          tmo_hit;
    logic [23:0]   addr_c;
    logic          rw_c;
    logic [3:0]    wdata_c;

    logic [7:0]    al_base;
    logic [7:0]    al_size;
    logic          al_fit;

    autoconfig_alloc u_alloc (
        .ptr       (ptr_q),
        .size_code (code_q),
        .base      (al_base),
        .size      (al_size),
        .fit       (al_fit)
    );

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            tmr_q      <= '0;
            ptr_q      <= SPACE_LO;
            nb_q       <= 4'd0;
            ns_q       <= 4'd0;
            code_q     <= 3'd0;
            base_q     <= 8'd0;
            size_q     <= 8'd0;
            cfg_we_q   <= 1'b0;
            cfg_base_q <= 8'd0;
            cfg_size_q <= 8'd0;
            cfg_idx_q  <= 3'd0;
        end else begin
            state_q    <= state_nxt;
            req_q      <= req_nxt;
            tmr_q      <= tmr_nxt;
            ptr_q      <= ptr_nxt;
            nb_q       <= nb_nxt;
            ns_q       <= ns_nxt;
            code_q     <= code_nxt;
            base_q     <= base_nxt;
            size_q     <= size_nxt;
            cfg_we_q   <= cfg_we_nxt;
            cfg_base_q <= cfg_base_nxt;
            cfg_size_q <= cfg_size_nxt;
            cfg_idx_q  <= cfg_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        req_nxt      = req_q;
        tmr_nxt      = tmr_q;
        ptr_nxt      = ptr_q;
        nb_nxt       = nb_q;
        ns_nxt       = ns_q;
        code_nxt     = code_q;
        base_nxt     = base_q;
        size_nxt     = size_q;
        cfg_we_nxt   = 1'b0;
        cfg_base_nxt = cfg_base_q;
        cfg_size_nxt = cfg_size_q;
        cfg_idx_nxt  = cfg_idx_q;

        bus_state = state_q inside {ST_RD_TYPE, ST_RD_SIZE, ST_WR_LO, ST_WR_HI, ST_WR_SHUT};
        ack_hit   = req_q & bus.bus_ack;
        tmo_hit   = req_q & ~bus.bus_ack & (tmr_q == '0);

        // Every bus state enters with req low, so a launch always follows a quiet cycle.
        if (bus_state) begin
            if (!req_q) begin
                req_nxt = 1'b1;
                tmr_nxt = TMR_LOAD;
            end else if (ack_hit || tmo_hit) begin
                req_nxt = 1'b0;
            end else begin
                tmr_nxt = tmr_q - 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RD_TYPE;
                    ptr_nxt   = SPACE_LO;
                    nb_nxt    = 4'd0;
                    ns_nxt    = 4'd0;
                end
            end
            ST_RD_TYPE: begin
                if (tmo_hit) begin
                    state_nxt = ST_DONE;
                end else if (ack_hit) begin
                    state_nxt = (bus.bus_rdata[3:2] == 2'b11) ? ST_RD_SIZE : ST_WR_SHUT;
                end
            end
            ST_RD_SIZE: begin
                if (tmo_hit) begin
                    state_nxt = ST_DONE;
                end else if (ack_hit) begin
                    code_nxt  = bus.bus_rdata[2:0];
                    state_nxt = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                base_nxt  = al_base;
                size_nxt  = al_size;
                state_nxt = al_fit ? ST_WR_LO : ST_WR_SHUT;
            end
            ST_WR_LO: begin
                if (tmo_hit) begin
                    state_nxt = ST_DONE;
                end else if (ack_hit) begin
                    state_nxt = ST_WR_HI;
                end
            end
            ST_WR_HI: begin
                if (tmo_hit) begin
                    state_nxt = ST_DONE;
                end else if (ack_hit) begin
                    cfg_we_nxt   = 1'b1;
                    cfg_base_nxt = base_q;
                    cfg_size_nxt = size_q;
                    cfg_idx_nxt  = nb_q[2:0];
                    ptr_nxt      = base_q + size_q;
                    nb_nxt       = nb_q + 4'd1;
                    state_nxt    = ST_NEXT;
                end
            end
            ST_WR_SHUT: begin
                if (tmo_hit) begin
                    state_nxt = ST_DONE;
                end else if (ack_hit) begin
                    ns_nxt    = ns_q + 4'd1;
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_nxt = (({1'b0, nb_q} + {1'b0, ns_q}) == MAX_CNT) ? ST_DONE : ST_RD_TYPE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_c  = ac_addr(AC_REG_TYPE);
        rw_c    = 1'b1;
        wdata_c = 4'h0;
        case (state_q)
            ST_RD_SIZE: addr_c = ac_addr(AC_REG_SIZE);
            ST_WR_LO: begin
                addr_c  = ac_addr(AC_REG_BASE_LO);
                rw_c    = 1'b0;
                wdata_c = base_q[3:0];
            end
            ST_WR_HI: begin
                addr_c  = ac_addr(AC_REG_BASE_HI);
                rw_c    = 1'b0;
                wdata_c = base_q[7:4];
            end
            ST_WR_SHUT: begin
                addr_c  = ac_addr(AC_REG_SHUT);
                rw_c    = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_rw    = rw_c;
    assign bus.bus_addr  = addr_c;
    assign bus.bus_wdata = wdata_c;

    assign done     = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign _cfgout  = (state_q == ST_IDLE);
    assign cfg_we   = cfg_we_q;
    assign cfg_base = cfg_base_q;
    assign cfg_size = cfg_size_q;
    assign cfg_idx  = cfg_idx_q;
    assign n_boards = nb_q;
    assign n_shut   = ns_q;
    assign mem_top  = ptr_q;

endmodule

// File: tb/tb_autoconfig_master.sv
// Bench for autoconfig_master: a board-chain responder, an allocation model derived from
// the AutoConfig rules, and a per-cycle compare process against that model.
module tb_autoconfig_master;

    localparam int MAXB = 8;

    logic       CLK = 1'b0;
    logic       _RST;
    logic       start;
    logic       _cfgout, busy, done, cfg_we;
    logic [7:0] cfg_base, cfg_size, mem_top;
    logic [2:0] cfg_idx;
    logic [3:0] n_boards, n_shut;

    autoconfig_master_if bus_if();

    autoconfig_master #(.TIMEOUT(64), .MAX_BOARDS(MAXB)) dut (
        .CLK      (CLK),
        ._RST     (_RST),
        .start    (start),
        .bus      (bus_if),
        ._cfgout  (_cfgout),
        .busy     (busy),
        .done     (done),
        .cfg_we   (cfg_we),
        .cfg_base (cfg_base),
        .cfg_size (cfg_size),
        .cfg_idx  (cfg_idx),
        .n_boards (n_boards),
        .n_shut   (n_shut),
        .mem_top  (mem_top)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [7:0] off; logic [3:0] dat; } wr_t;
    typedef struct { logic [7:0] base; logic [7:0] size; logic [2:0] idx; } cfg_t;

    int          n_pass = 0;
    int          n_tot  = 0;
    int          nbrd   = 0;
    logic [3:0]  brd_type [16];
    logic [3:0]  brd_size [16];
    int          brd_ptr = 0;
    int          lat = 0;
    logic [23:0] hold_addr = 24'h0;
    wr_t         exp_wr[$];
    cfg_t        exp_cfg[$];
    wr_t         act_wr[$];
    int          exp_nb, exp_ns, exp_top;
    int          req_cycles;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Walk the chain the way AutoConfig prescribes, with plain integer arithmetic.
    task automatic build_model();
        int ptr, nb, ns, code, units, base;
        bit fit;
        exp_wr.delete();
        exp_cfg.delete();
        ptr = 32; nb = 0; ns = 0;
        for (int i = 0; i < nbrd; i++) begin
            if (nb + ns == MAXB) break;
            if ((int'(brd_type[i]) / 4) != 3) begin
                exp_wr.push_back('{8'h4C, 4'h0});
                ns++;
                continue;
            end
            code  = int'(brd_size[i]) % 8;
            units = (code == 0) ? 128 : (2 ** (code - 1));
            if (code == 0) begin
                base = 32;
                fit  = (ptr == 32);
            end else begin
                base = ((ptr + units - 1) / units) * units;
                fit  = (base + units <= 160);
            end
            if (fit) begin
                exp_wr.push_back('{8'h4A, 4'(base % 16)});
                exp_wr.push_back('{8'h48, 4'(base / 16)});
                exp_cfg.push_back('{8'(base), 8'(units), 3'(nb)});
                ptr = base + units;
                nb++;
            end else begin
                exp_wr.push_back('{8'h4C, 4'h0});
                ns++;
            end
        end
        exp_nb = nb; exp_ns = ns; exp_top = ptr;
    endtask

    // Board chain: only the first unconfigured board answers; $48 or $4C moves the chain on.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 4'h0;
        forever begin
            @(posedge CLK); #1;
            bus_if.bus_ack   = 1'b0;
            bus_if.bus_rdata = 4'h0;
            if (_RST === 1'b1 && bus_if.bus_req === 1'b1 && brd_ptr < nbrd &&
                bus_if.bus_addr != hold_addr) begin
                if (wait_cnt < lat) wait_cnt++;
                else begin
                    wait_cnt = 0;
                    bus_if.bus_ack = 1'b1;
                    if (bus_if.bus_rw) begin
                        if (bus_if.bus_addr == 24'hE80000) bus_if.bus_rdata = brd_type[brd_ptr];
                        else if (bus_if.bus_addr == 24'hE80002) bus_if.bus_rdata = brd_size[brd_ptr];
                    end else if (bus_if.bus_addr == 24'hE80048 || bus_if.bus_addr == 24'hE8004C) begin
                        brd_ptr++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Compare process: writes and assignments against the model, handshake and _cfgout rules.
    initial begin
        logic prev_ack;
        wr_t  w;
        cfg_t c;
        prev_ack = 1'b0;
        forever begin
            @(negedge CLK);
            if (_RST !== 1'b1) begin
                prev_ack = 1'b0;
            end else begin
                if (prev_ack) chk("req_drops_after_ack", bus_if.bus_req, 1'b0);
                prev_ack = bus_if.bus_ack && bus_if.bus_req;
                chk("cfgout_vs_state", _cfgout, !(busy || done));
                if (bus_if.bus_ack && bus_if.bus_req && !bus_if.bus_rw) begin
                    act_wr.push_back('{bus_if.bus_addr[7:0], bus_if.bus_wdata});
                    if (exp_wr.size() == 0) chk("unexpected_write_addr", bus_if.bus_addr, 24'h0);
                    else begin
                        w = exp_wr.pop_front();
                        chk("write_addr", bus_if.bus_addr, 24'hE80000 | {16'h0, w.off});
                        chk("write_data", bus_if.bus_wdata, w.dat);
                    end
                end
                if (cfg_we) begin
                    if (exp_cfg.size() == 0) chk("unexpected_cfg_we_base", cfg_base, 8'h00);
                    else begin
                        c = exp_cfg.pop_front();
                        chk("cfg_base", cfg_base, c.base);
                        chk("cfg_size", cfg_size, c.size);
                        chk("cfg_idx", cfg_idx, c.idx);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        req_cycles = 0;
        for (int k = 0; k < 5000 && !done; k++) begin
            @(negedge CLK);
            if (bus_if.bus_req) req_cycles++;
        end
        chk({nm, ":done"}, done, 1'b1);
    endtask

    task automatic run_core(input string nm);
        brd_ptr = 0;
        act_wr.delete();
        pulse_start();
        wait_done(nm);
        @(negedge CLK);
        chk({nm, ":queues_drained"}, exp_wr.size() + exp_cfg.size(), 0);
        chk({nm, ":n_boards"}, n_boards, exp_nb);
        chk({nm, ":n_shut"}, n_shut, exp_ns);
        chk({nm, ":mem_top"}, mem_top, exp_top);
        chk({nm, ":busy"}, busy, 1'b0);
    endtask

    task automatic run(input string nm);
        build_model();
        run_core(nm);
    endtask

    task automatic set_board(input int i, input logic [3:0] t, input logic [3:0] s);
        brd_type[i] = t;
        brd_size[i] = s;
    endtask

    initial begin
        bit found;
        start = 1'b0;
        _RST  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset:bus_req", bus_if.bus_req, 1'b0);
        chk("reset:cfgout", _cfgout, 1'b1);
        chk("reset:busy_done", {busy, done, cfg_we}, 3'b000);
        chk("reset:mem_top", mem_top, 8'h20);
        chk("reset:counters", {n_boards, n_shut}, 8'h00);
        _RST = 1'b1;
        @(negedge CLK);
        chk("idle:cfgout", _cfgout, 1'b1);

        // Empty chain: one unanswered read, 64 request clocks.
        nbrd = 0; lat = 0;
        run("empty");
        chk("empty:req_cycles", req_cycles, 64);
        chk("empty:writes", act_wr.size(), 0);
        chk("empty:cfgout_done", _cfgout, 1'b0);

        // One 2MB board.
        nbrd = 1; lat = 1;
        set_board(0, 4'hE, 4'h6);
        run("one_2mb");
        chk("one_2mb:n_writes", act_wr.size(), 2);
        chk("one_2mb:wr0", {act_wr[0].off, act_wr[0].dat}, 12'h4A0);
        chk("one_2mb:wr1", {act_wr[1].off, act_wr[1].dat}, 12'h482);
        chk("one_2mb:cfg_base", cfg_base, 8'h20);
        chk("one_2mb:cfg_size", cfg_size, 8'd32);
        chk("one_2mb:mem_top", mem_top, 8'h40);

        // 512K then 2MB: second board realigned from $28 to $40.
        nbrd = 2; lat = 0;
        set_board(0, 4'hE, 4'h4);
        set_board(1, 4'hE, 4'h6);
        run("512k_2mb");
        chk("512k_2mb:wr3", {act_wr[3].off, act_wr[3].dat}, 12'h484);
        chk("512k_2mb:mem_top", mem_top, 8'h60);

        // Three 4MB boards: only the first fits.
        nbrd = 3; lat = 2;
        for (int i = 0; i < 3; i++) set_board(i, 4'hE, 4'h7);
        run("three_4mb");
        chk("three_4mb:first_base_hi", {act_wr[1].off, act_wr[1].dat}, 12'h484);
        chk("three_4mb:shut", {act_wr[2].off, act_wr[3].off}, 16'h4C4C);
        chk("three_4mb:counts", {n_boards, n_shut}, 8'h12);
        chk("three_4mb:mem_top", mem_top, 8'h80);

        // Bad type nibble: shut up, then the next board is probed and configured.
        nbrd = 2; lat = 0;
        set_board(0, 4'h5, 4'h6);
        set_board(1, 4'hE, 4'h6);
        run("bad_type");
        chk("bad_type:wr0", {act_wr[0].off, act_wr[0].dat}, 12'h4C0);
        chk("bad_type:counts", {n_boards, n_shut}, 8'h11);
        chk("bad_type:cfg_base", cfg_base, 8'h20);

        // 8MB boards: the first fills the space exactly, the second cannot fit.
        nbrd = 2; lat = 1;
        set_board(0, 4'hE, 4'h0);
        set_board(1, 4'hE, 4'h0);
        run("8mb");
        chk("8mb:cfg_size", cfg_size, 8'd128);
        chk("8mb:mem_top", mem_top, 8'hA0);
        chk("8mb:n_shut", n_shut, 4'd1);

        // MAX_BOARDS reached: ninth board is never probed.
        nbrd = 9; lat = 0;
        for (int i = 0; i < 9; i++) set_board(i, 4'h5, 4'h0);
        run("max_boards");
        chk("max_boards:n_shut", n_shut, 4'd8);
        chk("max_boards:chain_pos", brd_ptr, 8);

        // Write timeout in WR_LO: run ends with nothing assigned.
        nbrd = 1; lat = 0;
        set_board(0, 4'hE, 4'h6);
        hold_addr = 24'hE8004A;
        exp_wr.delete(); exp_cfg.delete();
        exp_nb = 0; exp_ns = 0; exp_top = 32;
        run_core("wr_timeout");
        chk("wr_timeout:writes", act_wr.size(), 0);
        hold_addr = 24'h0;

        // Reset during WR_HI before its ack.
        nbrd = 1; lat = 1;
        set_board(0, 4'hE, 4'h6);
        build_model();
        void'(exp_wr.pop_back());
        exp_cfg.delete();
        hold_addr = 24'hE80048;
        brd_ptr = 0;
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge CLK);
            if (bus_if.bus_req && bus_if.bus_addr == 24'hE80048) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_wr_hi:reached", found, 1'b1);
        #2 _RST = 1'b0;
        #1;
        chk("rst_wr_hi:bus_req", bus_if.bus_req, 1'b0);
        chk("rst_wr_hi:flags", {cfg_we, busy, done, _cfgout}, 4'b0001);
        chk("rst_wr_hi:mem_top", mem_top, 8'h20);
        chk("rst_wr_hi:lo_write_seen", exp_wr.size(), 0);
        repeat (2) @(negedge CLK);
        chk("rst_wr_hi:no_cfg_we", cfg_we, 1'b0);
        hold_addr = 24'h0;
        _RST = 1'b1;
        run("after_reset");
        chk("after_reset:cfg_base", cfg_base, 8'h20);
        chk("after_reset:mem_top", mem_top, 8'h40);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
